// File: rtl/booth_r4_datapath.sv
// Radix-4 Booth multiplier datapath: multiplicand, accumulator and multiplier
// shift chain, plus a valid/ready product output register with sequence checking.
module booth_r4_datapath #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     m_in,
  input  logic [WIDTH-1:0]     x_in,
  input  logic                 init,
  input  logic                 load_a,
  input  logic                 shift,
  input  logic                 fin,
  output logic [2:0]           q,
  output logic [2*WIDTH-1:0]   product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 seq_err
);

  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH / 2 + 1);
  localparam logic [CW-1:0] STEPS = CW'(WIDTH / 2);

  logic [WIDTH-1:0]   m_q, m_d;
  logic [AW-1:0]      a_q, a_d;
  logic [WIDTH-1:0]   qr_q, qr_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      step_q, step_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               fin_done_q, fin_done_d;

  logic [AW-1:0]      m_ext_s;
  logic [AW-1:0]      pp_s;
  logic               fin_attempt_s;
  logic               capture_s;
  logic               clash_s;
  logic               overrun_s;
  logic               fin_err_s;

  assign q         = {qr_q[1], qr_q[0], qm1_q};
  assign product   = prod_q;
  assign out_valid = valid_q;
  assign seq_err   = err_q;

  // Booth partial product selected by the current window
  always_comb begin
    m_ext_s = {{2{m_q[WIDTH-1]}}, m_q};
    pp_s    = '0;
    case (q)
      3'b001, 3'b010: pp_s = m_ext_s;
      3'b011:         pp_s = m_ext_s << 1;
      3'b100:         pp_s = AW'(0) - (m_ext_s << 1);
      3'b101, 3'b110: pp_s = AW'(0) - m_ext_s;
      default:        pp_s = '0;
    endcase
  end

  // Next-state logic for the arithmetic chain, capture and error tracking
  always_comb begin
    m_d        = m_q;
    a_d        = a_q;
    qr_d       = qr_q;
    qm1_d      = qm1_q;
    step_d     = step_q;
    prod_d     = prod_q;
    valid_d    = valid_q;

    // A capture attempt is armed by fin going high, or by fin after an init
    fin_attempt_s = fin && !fin_done_q && !init;
    fin_done_d    = fin && !init;
    clash_s       = !init && load_a && shift;
    overrun_s     = !init && !load_a && shift && (step_q == STEPS);
    capture_s     = fin_attempt_s && (step_q == STEPS) && (!valid_q || out_ready);
    fin_err_s     = fin_attempt_s && !capture_s;
    err_d         = err_q || clash_s || overrun_s || fin_err_s;

    if (init) begin
      m_d    = m_in;
      a_d    = '0;
      qr_d   = x_in;
      qm1_d  = 1'b0;
      step_d = '0;
    end else if (load_a) begin
      a_d = a_q + pp_s;
    end else if (shift && (step_q != STEPS)) begin
      qm1_d  = qr_q[1];
      qr_d   = {a_q[1:0], qr_q[WIDTH-1:2]};
      a_d    = {{2{a_q[AW-1]}}, a_q[AW-1:2]};
      step_d = step_q + CW'(1);
    end else begin
      step_d = step_q;
    end

    if (capture_s) begin
      prod_d  = {a_q[WIDTH-1:0], qr_q};
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q        <= '0;
      a_q        <= '0;
      qr_q       <= '0;
      qm1_q      <= 1'b0;
      step_q     <= '0;
      prod_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      fin_done_q <= 1'b0;
    end else begin
      m_q        <= m_d;
      a_q        <= a_d;
      qr_q       <= qr_d;
      qm1_q      <= qm1_d;
      step_q     <= step_d;
      prod_q     <= prod_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      fin_done_q <= fin_done_d;
    end
  end

endmodule

// File: tb/tb_booth_r4_datapath.sv
// Self-checking bench for booth_r4_datapath: directed corner cases plus random
// signed operand pairs against an integer-multiply reference model.
module tb_booth_r4_datapath;

  localparam int W  = 6;
  localparam int PW = 2 * W;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  m_in, x_in;
  logic          init, load_a, shift, fin, out_ready;
  logic [2:0]    q;
  logic [PW-1:0] product;
  logic          out_valid, seq_err;

  int checks = 0;
  int errors = 0;

  booth_r4_datapath #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .m_in(m_in), .x_in(x_in),
    .init(init), .load_a(load_a), .shift(shift), .fin(fin),
    .q(q), .product(product), .out_valid(out_valid),
    .out_ready(out_ready), .seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Booth window k of multiplier x: {x[2k+1], x[2k], x[2k-1]} with x[-1]=0
  function automatic logic [2:0] win(input logic [W-1:0] x, input int k);
    logic [W:0] ext;
    ext = {x, 1'b0};
    return ext[2*k+2 -: 3];
  endfunction

  function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] m, input logic [W-1:0] x);
    int mi, xi;
    mi = $signed(m);
    xi = $signed(x);
    return PW'(mi * xi);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_mul(input logic [W-1:0] m, input logic [W-1:0] x,
                         input int nsteps, input bit do_fin, input string tag);
    m_in = m; x_in = x; init = 1'b1;
    tick();
    init = 1'b0;
    for (int k = 0; k < nsteps; k++) begin
      check({tag, "_q"}, 32'(q), 32'(win(x, k)));
      if (win(x, k) != 3'b000 && win(x, k) != 3'b111) begin
        load_a = 1'b1; tick(); load_a = 1'b0;
      end
      shift = 1'b1; tick(); shift = 1'b0;
    end
    if (do_fin) begin
      fin = 1'b1; tick(); fin = 1'b0;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0]  rm, rx;
    logic [PW-1:0] p_exp;
    logic [2:0]    q_exp;

    rst_n = 1'b0; m_in = '0; x_in = '0;
    init = 1'b0; load_a = 1'b0; shift = 1'b0; fin = 1'b0; out_ready = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
    check("rst_product", 32'(product), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(seq_err), 32'd0);
    check("rst_q", 32'(q), 32'd0);

    // Nominal 7*3 with fin held high across the handshake
    run_mul(6'd7, 6'd3, W / 2, 1'b0, "nom");
    fin = 1'b1; tick();
    check("nom_prod", 32'(product), 32'd21);
    check("nom_valid", 32'(out_valid), 32'd1);
    tick(); tick();
    check("nom_hold_valid", 32'(out_valid), 32'd1);
    check("nom_hold_prod", 32'(product), 32'd21);
    out_ready = 1'b1; tick();
    check("nom_drop_valid", 32'(out_valid), 32'd0);
    tick();
    check("nom_no_recapture", 32'(out_valid), 32'd0);
    fin = 1'b0; out_ready = 1'b0;
    check("nom_err", 32'(seq_err), 32'd0);

    run_mul(6'h20, 6'h20, W / 2, 1'b1, "ext1");
    check("ext1_prod", 32'(product), 32'h400);
    consume();
    run_mul(6'd31, 6'h20, W / 2, 1'b1, "ext2");
    check("ext2_prod", 32'(product), 32'hC20);
    check("ext2_valid", 32'(out_valid), 32'd1);
    consume();

    for (int i = 0; i < 20; i++) begin
      rm = W'($urandom);
      rx = W'($urandom);
      run_mul(rm, rx, W / 2, 1'b1, "rnd");
      check("rnd_prod", 32'(product), 32'(ref_prod(rm, rx)));
      check("rnd_valid", 32'(out_valid), 32'd1);
      consume();
    end
    check("rnd_err", 32'(seq_err), 32'd0);

    // Back-pressure: second result dropped while first is unread
    run_mul(6'd5, 6'h3D, W / 2, 1'b1, "bp1");
    check("bp1_prod", 32'(product), 32'(ref_prod(6'd5, 6'h3D)));
    run_mul(6'd9, 6'd9, W / 2, 1'b1, "bp2");
    check("bp2_kept", 32'(product), 32'(ref_prod(6'd5, 6'h3D)));
    check("bp2_valid", 32'(out_valid), 32'd1);
    check("bp2_err", 32'(seq_err), 32'd1);
    consume();
    check("bp_drain", 32'(out_valid), 32'd0);

    // fin after only two shifts
    do_reset();
    run_mul(6'd7, 6'd3, 2, 1'b1, "early");
    check("early_valid", 32'(out_valid), 32'd0);
    check("early_err", 32'(seq_err), 32'd1);

    // Extra shift beyond the last step must not move the chain
    do_reset();
    run_mul(6'd13, 6'h2B, W / 2, 1'b0, "over");
    p_exp = ref_prod(6'd13, 6'h2B);
    q_exp = {p_exp[1], p_exp[0], 1'b1};
    check("over_q_before", 32'(q), 32'(q_exp));
    check("over_err_before", 32'(seq_err), 32'd0);
    shift = 1'b1; tick(); shift = 1'b0;
    check("over_q_after", 32'(q), 32'(q_exp));
    check("over_err", 32'(seq_err), 32'd1);
    fin = 1'b1; tick(); fin = 1'b0;
    check("over_prod", 32'(product), 32'(p_exp));

    // load_a with shift in the same cycle performs only the add
    do_reset();
    m_in = 6'd7; x_in = 6'd3; init = 1'b1; tick(); init = 1'b0;
    check("clash_q0", 32'(q), 32'b110);
    load_a = 1'b1; shift = 1'b1; tick(); load_a = 1'b0; shift = 1'b0;
    check("clash_q_unshifted", 32'(q), 32'b110);
    check("clash_err", 32'(seq_err), 32'd1);
    shift = 1'b1; tick(); shift = 1'b0;
    for (int k = 1; k < W / 2; k++) begin
      check("clash_qk", 32'(q), 32'(win(6'd3, k)));
      if (win(6'd3, k) != 3'b000 && win(6'd3, k) != 3'b111) begin
        load_a = 1'b1; tick(); load_a = 1'b0;
      end
      shift = 1'b1; tick(); shift = 1'b0;
    end
    fin = 1'b1; tick(); fin = 1'b0;
    check("clash_prod", 32'(product), 32'd21);

    // Reset mid-multiplication with an unread product present
    run_mul(6'd22, 6'h35, 2, 1'b0, "mid");
    rst_n = 1'b0;
    #1;
    check("mid_rst_prod", 32'(product), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_err", 32'(seq_err), 32'd0);
    check("mid_rst_q", 32'(q), 32'd0);
    rst_n = 1'b1;
    tick();
    run_mul(6'd22, 6'h35, W / 2, 1'b1, "fresh");
    check("fresh_prod", 32'(product), 32'(ref_prod(6'd22, 6'h35)));
    check("fresh_valid", 32'(out_valid), 32'd1);
    check("fresh_err", 32'(seq_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_r4_datapath.md
Name: booth_r4_datapath

Overview:
- Radix-4 Booth multiplier datapath: the register/adder stage driven by the Booth control unit.
- Holds the multiplicand, the accumulator and the multiplier shift register.
- Returns the 3-bit Booth window q[2:0] to the controller.
- Captures the final signed product into a valid/ready output register.

Parameters:
WIDTH, 6, operand width in bits; must be even and at least 4.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous reset, active-low.
m_in  in  WIDTH  multiplicand, two's complement; sampled on init.
x_in  in  WIDTH  multiplier, two's complement; sampled on init.
init  in  1  clear the datapath and load the operands.
load_a  in  1  add the Booth partial product into the accumulator.
shift  in  1  arithmetic right shift by 2 of the {A,Q,q_m1} chain.
fin  in  1  controller in final state; capture the product.
q  out  3  Booth window {Q[1],Q[0],q_m1}.
product  out  2*WIDTH  signed product register.
out_valid  out  1  product holds an unread result.
out_ready  in  1  consumer accepts the product.
seq_err  out  1  sticky control-sequence error flag.

Behaviour:
- Internal registers:
  - M: WIDTH bits.
  - A: WIDTH+2 bits, signed.
  - Q: WIDTH bits.
  - q_m1: 1 bit.
  - step_cnt: counts 0..WIDTH/2.
- Reset (rst_n=0, asynchronous): all internal registers and product are 0; out_valid=0, seq_err=0, q=3'b000.
- Control priority per clock edge: init > load_a > shift. init also clears step_cnt.
- load_a and shift in the same cycle: only load_a is performed, and seq_err is set.
- init: M<=m_in, A<=0, Q<=x_in, q_m1<=0, step_cnt<=0. out_valid, product and seq_err are unchanged.
- load_a: A <= A + PP, computed in WIDTH+2 bits, where PP depends on q:
  - 000 or 111: 0.
  - 001 or 010: +sext(M).
  - 011: +2*sext(M).
  - 100: -2*sext(M).
  - 101 or 110: -sext(M).
  - Wrap-around in WIDTH+2 bits is impossible for legal sequences; no overflow handling.
- shift:
  - q_m1<=Q[1].
  - Q<={A[1:0],Q[WIDTH-1:2]}.
  - A<=A>>>2 (sign-extended).
  - step_cnt<=step_cnt+1, saturating at WIDTH/2.
  - A shift attempted when step_cnt==WIDTH/2 sets seq_err and leaves A, Q and q_m1 unchanged.
- q is combinational from registers: updates the cycle after init, load_a or shift (one-cycle latency from command).
- fin is level-sensitive; the capture is edge-detected internally.
  - Capture occurs on the first cycle fin is high after being low, or after an init.
  - Capture condition: step_cnt==WIDTH/2 and (out_valid==0 or out_ready==1).
  - On capture: product <= {A[WIDTH-1:0],Q} and out_valid<=1 next cycle.
  - fin held high for many cycles yields exactly one capture per multiplication.
- fin capture with step_cnt!=WIDTH/2: no capture, seq_err set.
- fin capture while out_valid=1 and out_ready=0: result is dropped, seq_err set, and the old product is preserved.
- Output handshake:
  - out_valid & out_ready clears out_valid next cycle unless a capture happens in the same cycle; a capture keeps out_valid=1 with the new product.
  - product is stable while out_valid=1.
- seq_err clears only on reset.
- Reset asserted mid-operation: immediate return to reset values; no partial product is ever presented.

Test Plan:
- Reset: rst_n=0 then 1 -> product=0, out_valid=0, seq_err=0, q=000.
- Nominal, WIDTH=6: m_in=7, x_in=3; init, then load_a/shift pairs as the Booth window dictates (3 shifts), fin=1 -> q=3'b110 after init; product=12'd21, out_valid=1 until out_ready.
- Extremes: m_in=-32, x_in=-32 -> product=12'h400 (1024); m_in=31, x_in=-32 -> product=12'hC20 (-992). Random signed pairs checked against a reference model.
- Back-pressure: hold out_ready=0, run a second multiplication to fin -> first product retained, seq_err=1. Then out_ready=1 -> out_valid drops next cycle.
- Sequence errors: fin after only 2 shifts -> no capture, seq_err=1. A 4th shift -> A/Q unchanged. load_a with shift in the same cycle -> add only, seq_err=1.
- Reset mid-multiplication after the 2nd shift -> all outputs zero immediately; a fresh init still yields a correct product.
